// File: rtl/matrix_core_sequencer_pkg.sv
// Shared constants, opcodes and FSM state type for the matrix-core sequencer.
package matrix_core_sequencer_pkg;

   localparam int unsigned DATA_WIDTH                 = 8;
   localparam int unsigned MAT_DIM                    = 4;
   localparam int unsigned X_DEPTH                    = MAT_DIM;
   localparam int unsigned FETCH_ENGINE_OPCODE_LENGTH = 4;

   localparam logic [FETCH_ENGINE_OPCODE_LENGTH-1:0] MATRIX_CORE_LOAD_W  = FETCH_ENGINE_OPCODE_LENGTH'(1);
   localparam logic [FETCH_ENGINE_OPCODE_LENGTH-1:0] MATRIX_CORE_LOAD_X  = FETCH_ENGINE_OPCODE_LENGTH'(2);
   localparam logic [FETCH_ENGINE_OPCODE_LENGTH-1:0] MATRIX_CORE_COMPUTE = FETCH_ENGINE_OPCODE_LENGTH'(3);

   typedef enum logic [3:0] {
      IDLE,
      LOAD_W,
      LOAD_X,
      RD_W,
      WT_W,
      RD_X,
      WT_X,
      OUT,
      DONE
   } seq_state_e;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_core_sequencer_mac.sv
// Accumulator for one y row: acc <= acc + a*b, all arithmetic modulo 2^DW.
module matrix_core_mac #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] acc_o
);

   logic [DW-1:0] acc_q, acc_d;
   logic [DW-1:0] prod;

   assign prod  = a_i * b_i;
   assign acc_o = acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + prod;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/matrix_core_sequencer.sv
// Loads W and x into the matrix-core SRAM from the input stream, then computes
// y = W*x through the SRAM read port and streams one y word per row.
module matrix_core_sequencer #(
   parameter int unsigned DW      = matrix_core_sequencer_pkg::DATA_WIDTH,
   parameter int unsigned MAT_DIM = matrix_core_sequencer_pkg::MAT_DIM,
   parameter int unsigned OPW     = matrix_core_sequencer_pkg::FETCH_ENGINE_OPCODE_LENGTH,
   localparam int unsigned RW     = matrix_core_sequencer_pkg::idx_w(MAT_DIM)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   output logic           busy_o,
   output logic           done_o,
   input  logic           in_vld_i,
   output logic           in_rdy_o,
   input  logic [DW-1:0]  in_data_i,
   output logic           mem_we_o,
   output logic           mem_re_o,
   output logic           mem_vld_o,
   input  logic           mem_rdy_i,
   output logic [OPW-1:0] mem_state_o,
   output logic [DW-1:0]  mem_addr_o,
   output logic [DW-1:0]  mem_wdata_o,
   input  logic [DW-1:0]  mem_rdata_i,
   input  logic           mem_rdata_vld_i,
   output logic           y_vld_o,
   input  logic           y_rdy_i,
   output logic [DW-1:0]  y_data_o,
   output logic [RW-1:0]  y_row_o
);

   import matrix_core_sequencer_pkg::*;

   localparam int unsigned NW = MAT_DIM * MAT_DIM;
   localparam int unsigned CW = idx_w(NW);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   logic [RW-1:0] col_q, col_d;
   logic [DW-1:0] w_q, w_d;
   logic          mac_clr;
   logic          mac_en;
   logic [DW-1:0] acc;

   matrix_core_mac #(.DW(DW)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (w_q),
      .b_i   (mem_rdata_i),
      .acc_o (acc)
   );

   assign y_data_o = acc;
   assign y_row_o  = row_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         w_q     <= w_d;
      end
   end

   // Next state plus SRAM/stream decode; y_rdy only ever affects state, never mem_*.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      w_d         = w_q;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;
      busy_o      = (state_q != IDLE);
      done_o      = 1'b0;
      in_rdy_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_re_o    = 1'b0;
      mem_vld_o   = 1'b0;
      mem_state_o = OPW'(MATRIX_CORE_LOAD_W);
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      y_vld_o     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD_W;
               cnt_d   = '0;
            end
         end
         LOAD_W: begin
            in_rdy_o    = mem_rdy_i;
            mem_vld_o   = in_vld_i;
            mem_we_o    = 1'b1;
            mem_addr_o  = DW'(cnt_q);
            mem_wdata_o = in_data_i;
            if (in_vld_i && mem_rdy_i) begin
               if (cnt_q == CW'(NW - 1)) begin
                  state_d = LOAD_X;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         LOAD_X: begin
            in_rdy_o    = mem_rdy_i;
            mem_vld_o   = in_vld_i;
            mem_we_o    = 1'b1;
            mem_state_o = OPW'(MATRIX_CORE_LOAD_X);
            mem_addr_o  = DW'(cnt_q);
            mem_wdata_o = in_data_i;
            if (in_vld_i && mem_rdy_i) begin
               if (cnt_q == CW'(MAT_DIM - 1)) begin
                  state_d = RD_W;
                  cnt_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
                  mac_clr = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         RD_W: begin
            mem_re_o   = 1'b1;
            mem_vld_o  = 1'b1;
            mem_addr_o = DW'(row_q) * DW'(MAT_DIM) + DW'(col_q);
            if (mem_rdy_i) begin
               state_d = WT_W;
            end
         end
         WT_W: begin
            if (mem_rdata_vld_i) begin
               w_d     = mem_rdata_i;
               state_d = RD_X;
            end
         end
         RD_X: begin
            mem_re_o    = 1'b1;
            mem_vld_o   = 1'b1;
            mem_state_o = OPW'(MATRIX_CORE_LOAD_X);
            mem_addr_o  = DW'(col_q);
            if (mem_rdy_i) begin
               state_d = WT_X;
            end
         end
         WT_X: begin
            if (mem_rdata_vld_i) begin
               mac_en = 1'b1;
               if (col_q == RW'(MAT_DIM - 1)) begin
                  state_d = OUT;
               end else begin
                  col_d   = col_q + RW'(1);
                  state_d = RD_W;
               end
            end
         end
         OUT: begin
            y_vld_o = 1'b1;
            if (y_rdy_i) begin
               mac_clr = 1'b1;
               col_d   = '0;
               if (row_q == RW'(MAT_DIM - 1)) begin
                  row_d   = '0;
                  state_d = DONE;
               end else begin
                  row_d   = row_q + RW'(1);
                  state_d = RD_W;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
